// File: rtl/delay_line_sequencer.sv
// Shares one single-port delay-line RAM between one write and NUM_TAPS tap reads per sample tick (DELAY_LINE_INTERP_EN: linear fractional interpolation).
// Latency tick -> tap_valid: NUM_TAPS+3 cycles, or 2*NUM_TAPS+4 with interpolation.
// No backpressure: a tick arriving while busy is dropped and flagged in sticky overrun.
module delay_line_sequencer #(
   parameter int ADDR_W   = 11,
   parameter int DATA_W   = 32,
   parameter int NUM_TAPS = 3,
   parameter int FRAC_W   = 4
) (
   input  logic                                CLOCK_50,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                sample_tick,
   input  logic [DATA_W-1:0]                   sample_in,
   input  logic [NUM_TAPS*(ADDR_W+FRAC_W)-1:0] tap_delay,
   output logic [ADDR_W-1:0]                   mem_addr,
   output logic                                mem_we,
   output logic [DATA_W-1:0]                   mem_wdata,
   input  logic [DATA_W-1:0]                   mem_rdata,
   output logic [NUM_TAPS*DATA_W-1:0]          tap_data,
   output logic                                tap_valid,
   output logic                                busy,
   output logic                                overrun,
   input  logic                                clear_overrun
);
   localparam int DLY_W = ADDR_W + FRAC_W;
`ifdef DELAY_LINE_INTERP_EN
   localparam int RD_CNT = 2 * NUM_TAPS;
   localparam logic [ADDR_W-1:0] D_MAX = {{(ADDR_W-1){1'b1}}, 1'b0};
`else
   localparam int RD_CNT = NUM_TAPS;
`endif
   localparam int CNT_W = (RD_CNT > 1) ? $clog2(RD_CNT) : 1;
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CNT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_READ, S_DRAIN, S_CALC, S_DONE
   } state_t;

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    rd_cnt;
   logic [CNT_W-1:0]    tap_sel;
   logic [ADDR_W-1:0]   wr_ptr;
   logic [ADDR_W-1:0]   base_ptr;
   logic [ADDR_W-1:0]   sel_dly;
   logic [ADDR_W-1:0]   rd_addr;
   logic [DATA_W-1:0]   sample_q;
   logic [ADDR_W-1:0]   dly_q [NUM_TAPS];
   logic [DATA_W-1:0]   s0_q  [NUM_TAPS];
   logic                rd_pend;
   logic [CNT_W-1:0]    rd_pend_idx;
   logic [NUM_TAPS*DATA_W-1:0] tap_q;
   logic                accept;
   logic                tick_while_busy;
`ifdef DELAY_LINE_INTERP_EN
   logic [FRAC_W-1:0]   frac_q [NUM_TAPS];
   logic [DATA_W-1:0]   s1_q   [NUM_TAPS];
`else
   logic [NUM_TAPS*FRAC_W-1:0] unused_frac;
`endif

   function automatic logic [ADDR_W-1:0] clamp_dly(input logic [ADDR_W-1:0] d);
      logic [ADDR_W-1:0] r;
      r = d;
      if (d == '0) r = ADDR_W'(1);
`ifdef DELAY_LINE_INTERP_EN
      if (d > D_MAX) r = D_MAX;
`endif
      return r;
   endfunction

`ifdef DELAY_LINE_INTERP_EN
   // s0 + ((s1 - s0) * frac) >>> FRAC_W, widened so the difference cannot overflow
   function automatic logic [DATA_W-1:0] interp(input logic [DATA_W-1:0] s0,
                                                input logic [DATA_W-1:0] s1,
                                                input logic [FRAC_W-1:0] f);
      logic signed [DATA_W:0]        diff;
      logic signed [DATA_W+FRAC_W:0] prod;
      diff = $signed({s1[DATA_W-1], s1}) - $signed({s0[DATA_W-1], s0});
      prod = (DATA_W+FRAC_W+1)'(diff) * $signed({{(DATA_W+1){1'b0}}, f});
      prod = prod >>> FRAC_W;
      return s0 + prod[DATA_W-1:0];
   endfunction
`endif

   assign accept          = sample_tick && enable && (state == S_IDLE);
   assign tick_while_busy = sample_tick && enable && (state != S_IDLE);
   assign busy            = (state != S_IDLE);
   assign tap_valid       = (state == S_DONE);
   assign tap_data        = tap_q;

`ifdef DELAY_LINE_INTERP_EN
   assign tap_sel = rd_cnt >> 1;
`else
   assign tap_sel = rd_cnt;
   always_comb begin
      unused_frac = '0;
      for (int k = 0; k < NUM_TAPS; k++)
         unused_frac[k*FRAC_W +: FRAC_W] = tap_delay[k*DLY_W +: FRAC_W];
   end
`endif

   always_comb begin
      sel_dly = '0;
      for (int k = 0; k < NUM_TAPS; k++)
         if (tap_sel == CNT_W'(k)) sel_dly = dly_q[k];
`ifdef DELAY_LINE_INTERP_EN
      rd_addr = base_ptr - sel_dly - ADDR_W'(rd_cnt[0]);
`else
      rd_addr = base_ptr - sel_dly;
`endif
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_WRITE;
         S_WRITE: begin
            mem_addr  = base_ptr;
            mem_we    = 1'b1;
            mem_wdata = sample_q;
            state_nxt = S_READ;
         end
         S_READ: begin
            mem_addr = rd_addr;
            if (rd_cnt == RD_LAST) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
`ifdef DELAY_LINE_INTERP_EN
            state_nxt = S_CALC;
`else
            state_nxt = S_DONE;
`endif
         end
         S_CALC:  state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         base_ptr    <= '0;
         sample_q    <= '0;
         rd_cnt      <= '0;
         rd_pend     <= 1'b0;
         rd_pend_idx <= '0;
         tap_q       <= '0;
         overrun     <= 1'b0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            dly_q[k] <= '0;
            s0_q[k]  <= '0;
`ifdef DELAY_LINE_INTERP_EN
            frac_q[k] <= '0;
            s1_q[k]   <= '0;
`endif
         end
      end else begin
         if (accept) begin
            base_ptr <= wr_ptr;
            sample_q <= sample_in;
            for (int k = 0; k < NUM_TAPS; k++) begin
               dly_q[k] <= clamp_dly(tap_delay[k*DLY_W+FRAC_W +: ADDR_W]);
`ifdef DELAY_LINE_INTERP_EN
               frac_q[k] <= tap_delay[k*DLY_W +: FRAC_W];
`endif
            end
         end
         if (state == S_WRITE) wr_ptr <= wr_ptr + ADDR_W'(1);
         rd_cnt      <= (state == S_READ && rd_cnt != RD_LAST) ? rd_cnt + CNT_W'(1) : '0;
         rd_pend     <= (state == S_READ);
         rd_pend_idx <= rd_cnt;
         // read data lands one cycle after its address, so capture trails READ by one
         if (rd_pend) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
`ifdef DELAY_LINE_INTERP_EN
               if (rd_pend_idx == CNT_W'(2*k))   s0_q[k] <= mem_rdata;
               if (rd_pend_idx == CNT_W'(2*k+1)) s1_q[k] <= mem_rdata;
`else
               if (rd_pend_idx == CNT_W'(k)) s0_q[k] <= mem_rdata;
`endif
            end
         end
`ifdef DELAY_LINE_INTERP_EN
         if (state == S_CALC)
            for (int k = 0; k < NUM_TAPS; k++)
               tap_q[k*DATA_W +: DATA_W] <= interp(s0_q[k], s1_q[k], frac_q[k]);
`else
         if (state == S_DRAIN)
            for (int k = 0; k < NUM_TAPS; k++)
               tap_q[k*DATA_W +: DATA_W] <= (k == NUM_TAPS-1) ? mem_rdata : s0_q[k];
`endif
         if (tick_while_busy)    overrun <= 1'b1;
         else if (clear_overrun) overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_delay_line_sequencer.sv
// Directed self-checking bench for delay_line_sequencer with a behavioural 1-cycle-read RAM.
module tb_delay_line_sequencer;
   localparam int N  = 3;
   localparam int AW = 11;
   localparam int DW = 32;
`ifdef DELAY_LINE_INTERP_EN
   localparam int LAT     = 2*N + 4;
   localparam int RD_STEP = 2;
   localparam int FRAC_T  = 0;
`else
   localparam int LAT     = N + 3;
   localparam int RD_STEP = 1;
   localparam int FRAC_T  = 15;
`endif
   localparam int RD_CNT = N * RD_STEP;
   localparam int GAP    = LAT + 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              sample_tick = 1'b0;
   logic              clear_overrun = 1'b0;
   logic [DW-1:0]     sample_in = '0;
   logic [N*15-1:0]   tap_delay = '0;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata = '0;
   logic [N*DW-1:0]   tap_data;
   logic              tap_valid;
   logic              busy;
   logic              overrun;

   logic [DW-1:0]     ram [2**AW];

   int                checks = 0;
   int                errors = 0;
   int                obs_vcyc, obs_nvalid, obs_nwr, obs_nbusy;
   logic [AW-1:0]     obs_wr_addr;
   logic [DW-1:0]     obs_wr_data;
   logic [AW-1:0]     obs_rd [6];
   logic [N*DW-1:0]   obs_tap;

   delay_line_sequencer dut (
      .CLOCK_50(clk), .reset(reset), .enable(enable), .sample_tick(sample_tick),
      .sample_in(sample_in), .tap_delay(tap_delay), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .tap_data(tap_data), .tap_valid(tap_valid), .busy(busy),
      .overrun(overrun), .clear_overrun(clear_overrun)
   );

   always #10 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   function automatic logic [N*15-1:0] dly3(input int d0, input int d1, input int d2, input int f);
      return {11'(d2), 4'(f), 11'(d1), 4'(f), 11'(d0), 4'(f)};
   endfunction

   // Issues a tick in cycle 0 and records DUT activity for cycles 1..win-1.
   task automatic run_tick(input logic [DW-1:0] s, input logic [N*15-1:0] d, input int win,
                           input int t2, input bit clr2, input int en_off);
      sample_in = s; tap_delay = d; sample_tick = 1'b1;
      obs_vcyc = -1; obs_nvalid = 0; obs_nwr = 0; obs_nbusy = 0;
      obs_wr_addr = '0; obs_wr_data = '0; obs_tap = '0;
      for (int i = 0; i < 6; i++) obs_rd[i] = '0;
      @(posedge clk); #1;
      for (int c = 1; c < win; c++) begin
         sample_tick   = (c == t2);
         clear_overrun = (c == t2) && clr2;
         if (c == en_off) enable = 1'b0;
         if (mem_we) begin obs_nwr++; obs_wr_addr = mem_addr; obs_wr_data = mem_wdata; end
         if (busy) obs_nbusy++;
         if (c >= 2 && c < 2 + RD_CNT) obs_rd[c-2] = mem_addr;
         if (tap_valid) begin
            obs_nvalid++;
            if (obs_vcyc < 0) begin obs_vcyc = c; obs_tap = tap_data; end
         end
         @(posedge clk); #1;
      end
      sample_tick = 1'b0; clear_overrun = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; sample_tick = 1'b0; clear_overrun = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", mem_we); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %0h want 0", mem_addr); end
      checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata got %0h want 0", mem_wdata); end
      checks++; if (tap_data !== '0) begin errors++; $display("FAIL reset_tap_data got %0h want 0", tap_data); end
      checks++; if (tap_valid !== 1'b0) begin errors++; $display("FAIL reset_tap_valid got %0b want 0", tap_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %0b want 0", overrun); end
      #1 reset = 1'b0;
      @(posedge clk); #1;
      enable = 1'b1;
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp_t [N];
      logic [AW-1:0] exp_a [N];
      exp_t = '{32'h108, 32'h107, 32'h106};
      exp_a = '{11'd8, 11'd7, 11'd6};
      for (int n = 0; n < 10; n++) begin
         run_tick(32'h100 + n, dly3(1, 2, 3, 0), 20, -1, 1'b0, -1);
         if (n == 0) begin
            checks++; if (obs_wr_addr !== 11'd0) begin errors++; $display("FAIL basic_first_wr_addr got %0d want 0", obs_wr_addr); end
         end
      end
      checks++; if (obs_vcyc !== LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", obs_vcyc, LAT); end
      checks++; if (obs_nvalid !== 1) begin errors++; $display("FAIL basic_nvalid got %0d want 1", obs_nvalid); end
      checks++; if (obs_wr_addr !== 11'd9) begin errors++; $display("FAIL basic_wr_addr got %0d want 9", obs_wr_addr); end
      checks++; if (obs_wr_data !== 32'h109) begin errors++; $display("FAIL basic_wr_data got %0h want 109", obs_wr_data); end
      for (int k = 0; k < N; k++) begin
         checks++; if (obs_rd[k*RD_STEP] !== exp_a[k]) begin errors++; $display("FAIL basic_rd_addr%0d got %0d want %0d", k, obs_rd[k*RD_STEP], exp_a[k]); end
         checks++; if (obs_tap[k*DW +: DW] !== exp_t[k]) begin errors++; $display("FAIL basic_tap%0d got %0h want %0h", k, obs_tap[k*DW +: DW], exp_t[k]); end
      end
   endtask

   task automatic test_wrap();
      int bad;
      bad = 0;
      do_reset();
      for (int i = 0; i < 2050; i++) begin
         run_tick(DW'(i), dly3(480, 480, 480, 0), GAP, -1, 1'b0, -1);
         if (obs_nvalid != 1) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_missing_valid got %0d want 0", bad); end
      checks++; if (obs_vcyc !== LAT) begin errors++; $display("FAIL wrap_latency got %0d want %0d", obs_vcyc, LAT); end
      checks++; if (obs_wr_addr !== 11'd1) begin errors++; $display("FAIL wrap_wr_addr got %0d want 1", obs_wr_addr); end
      for (int k = 0; k < N; k++) begin
         checks++; if (obs_rd[k*RD_STEP] !== 11'd1569) begin errors++; $display("FAIL wrap_rd_addr%0d got %0d want 1569", k, obs_rd[k*RD_STEP]); end
         checks++; if (obs_tap[k*DW +: DW] !== 32'd1569) begin errors++; $display("FAIL wrap_tap%0d got %0d want 1569", k, obs_tap[k*DW +: DW]); end
      end
   endtask

   task automatic test_clamp();
      int reread;
      logic [DW-1:0] exp_t [N];
      run_tick(32'hC0, dly3(0, 0, 0, 0), 20, -1, 1'b0, -1);
      reread = 0;
      for (int i = 0; i < RD_CNT; i++) if (obs_rd[i] === obs_wr_addr) reread++;
      checks++; if (reread !== 0) begin errors++; $display("FAIL clamp_reread got %0d want 0", reread); end
      checks++; if (obs_wr_addr !== 11'd2) begin errors++; $display("FAIL clamp_wr_addr got %0d want 2", obs_wr_addr); end
      for (int k = 0; k < N; k++) begin
         checks++; if (obs_rd[k*RD_STEP] !== 11'd1) begin errors++; $display("FAIL clamp_rd_addr%0d got %0d want 1", k, obs_rd[k*RD_STEP]); end
         checks++; if (obs_tap[k*DW +: DW] !== 32'd2049) begin errors++; $display("FAIL clamp_tap%0d got %0d want 2049", k, obs_tap[k*DW +: DW]); end
      end
      exp_t = '{32'hC0, 32'hC0, 32'd2046};
      run_tick(32'hC1, dly3(0, 1, 5, FRAC_T), 20, -1, 1'b0, -1);
      for (int k = 0; k < N; k++) begin
         checks++; if (obs_tap[k*DW +: DW] !== exp_t[k]) begin errors++; $display("FAIL clamp2_tap%0d got %0h want %0h", k, obs_tap[k*DW +: DW], exp_t[k]); end
      end
   endtask

   task automatic test_overrun();
      run_tick(32'hD0, dly3(1, 1, 1, 0), 20, 2, 1'b0, -1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %0b want 1", overrun); end
      checks++; if (obs_nvalid !== 1) begin errors++; $display("FAIL ovr_nvalid got %0d want 1", obs_nvalid); end
      checks++; if (obs_nwr !== 1) begin errors++; $display("FAIL ovr_nwr got %0d want 1", obs_nwr); end
      checks++; if (obs_tap[DW-1:0] !== 32'hC1) begin errors++; $display("FAIL ovr_tap0 got %0h want c1", obs_tap[DW-1:0]); end
      run_tick(32'hD1, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      checks++; if (obs_wr_addr !== 11'd5) begin errors++; $display("FAIL ovr_wr_ptr got %0d want 5", obs_wr_addr); end
      checks++; if (obs_tap[DW-1:0] !== 32'hD0) begin errors++; $display("FAIL ovr_next_tap0 got %0h want d0", obs_tap[DW-1:0]); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b want 1", overrun); end
      clear_overrun = 1'b1; @(posedge clk); #1; clear_overrun = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %0b want 0", overrun); end
      run_tick(32'hD2, dly3(1, 1, 1, 0), 20, 3, 1'b1, -1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %0b want 1", overrun); end
      clear_overrun = 1'b1; @(posedge clk); #1; clear_overrun = 1'b0;
      run_tick(32'hE0, dly3(1, 1, 1, 0), 20, 3, 1'b0, 2);
      checks++; if (obs_nvalid !== 1) begin errors++; $display("FAIL endrop_nvalid got %0d want 1", obs_nvalid); end
      checks++; if (obs_vcyc !== LAT) begin errors++; $display("FAIL endrop_latency got %0d want %0d", obs_vcyc, LAT); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL endrop_overrun got %0b want 0", overrun); end
      checks++; if (obs_tap[DW-1:0] !== 32'hD2) begin errors++; $display("FAIL endrop_tap0 got %0h want d2", obs_tap[DW-1:0]); end
      run_tick(32'hE1, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      checks++; if (obs_nbusy !== 0) begin errors++; $display("FAIL disabled_busy got %0d want 0", obs_nbusy); end
      checks++; if (obs_nwr !== 0) begin errors++; $display("FAIL disabled_nwr got %0d want 0", obs_nwr); end
      enable = 1'b1;
   endtask

   task automatic test_reset_mid();
      int nv, nw;
      sample_in = 32'hF0; tap_delay = dly3(1, 1, 1, 0); sample_tick = 1'b1;
      @(posedge clk); #1; sample_tick = 1'b0;
      @(posedge clk); #1; sample_tick = 1'b1;
      @(posedge clk); #1; sample_tick = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %0b want 1", busy); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rstmid_overrun_pre got %0b want 1", overrun); end
      reset = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_mem_we got %0b want 0", mem_we); end
      checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rstmid_mem_addr got %0h want 0", mem_addr); end
      checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL rstmid_mem_wdata got %0h want 0", mem_wdata); end
      checks++; if (tap_data !== '0) begin errors++; $display("FAIL rstmid_tap_data got %0h want 0", tap_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %0b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %0b want 0", overrun); end
      nv = 0; nw = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 1) reset = 1'b0;
         if (tap_valid) nv++;
         if (mem_we) nw++;
      end
      checks++; if (nv !== 0) begin errors++; $display("FAIL rstmid_tap_valid got %0d want 0", nv); end
      checks++; if (nw !== 0) begin errors++; $display("FAIL rstmid_writes got %0d want 0", nw); end
      run_tick(32'h1234, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      checks++; if (obs_wr_addr !== 11'd0) begin errors++; $display("FAIL rstmid_next_wr_addr got %0d want 0", obs_wr_addr); end
      checks++; if (obs_tap[DW-1:0] !== 32'd2047) begin errors++; $display("FAIL rstmid_next_tap0 got %0d want 2047", obs_tap[DW-1:0]); end
   endtask

`ifdef DELAY_LINE_INTERP_EN
   task automatic test_interp();
      logic [DW-1:0] exp_t [N];
      exp_t = '{32'd150, 32'd175, 32'd250};
      do_reset();
      run_tick(32'd200, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      run_tick(32'd100, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      run_tick(32'd300, dly3(1, 1, 1, 0), 20, -1, 1'b0, -1);
      run_tick(32'd0, {11'd1, 4'd4, 11'd2, 4'd12, 11'd2, 4'd8}, 20, -1, 1'b0, -1);
      checks++; if (obs_vcyc !== 2*N+4) begin errors++; $display("FAIL interp_latency got %0d want %0d", obs_vcyc, 2*N+4); end
      checks++; if (obs_rd[0] !== 11'd1) begin errors++; $display("FAIL interp_rdA got %0d want 1", obs_rd[0]); end
      checks++; if (obs_rd[1] !== 11'd0) begin errors++; $display("FAIL interp_rdA1 got %0d want 0", obs_rd[1]); end
      for (int k = 0; k < N; k++) begin
         checks++; if (obs_tap[k*DW +: DW] !== exp_t[k]) begin errors++; $display("FAIL interp_tap%0d got %0d want %0d", k, obs_tap[k*DW +: DW], exp_t[k]); end
      end
   endtask
`endif

   initial begin
      #3000000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_clamp();
      test_overrun();
      test_reset_mid();
`ifdef DELAY_LINE_INTERP_EN
      test_interp();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/delay_line_sequencer.md
Name: delay_line_sequencer

Overview:
- Time-multiplexes one single-port delay-line RAM (2^ADDR_W words) between one write and NUM_TAPS tap reads per audio sample.
- Runs at CLOCK_50. Each sample_tick triggers one fixed access schedule.
- Serves the chorus/flanger/delay effects: each effect supplies its per-voice delays, and the sequencer returns the delayed samples as one packed bus.

Parameters:
- ADDR_W, 11, RAM address width; the delay line holds 2^ADDR_W samples.
- DATA_W, 32, sample width (signed two's complement).
- NUM_TAPS, 3, number of read taps (voices) per sample, 1..8.
- FRAC_W, 4, fractional delay bits carried on each tap delay input.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  when 0, ticks are ignored and the block stays in IDLE.
- sample_tick  in  1  one-cycle strobe per audio sample, CLOCK_50 domain.
- sample_in  in  DATA_W  sample to write; sampled on an accepted tick.
- tap_delay  in  NUM_TAPS*(ADDR_W+FRAC_W)  packed per-tap delay; tap k occupies slice k. Integer part in upper ADDR_W bits, fraction in lower FRAC_W bits.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after its address is presented.
- tap_data  out  NUM_TAPS*DATA_W  packed delayed samples, tap k in slice k.
- tap_valid  out  1  one-cycle pulse when tap_data updates.
- busy  out  1  high whenever state is not IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.
- clear_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset (asynchronous, immediate):
  - state returns to IDLE; wr_ptr=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - tap_data=0, tap_valid=0, busy=0, overrun=0.
  - Reset asserted mid-sequence aborts the sequence; no further RAM write or read occurs.
- States: IDLE -> WRITE -> READ (NUM_TAPS cycles, tap index k=0..N-1) -> DRAIN (1 cycle) -> DONE (1 cycle) -> IDLE.
- Tick acceptance:
  - A tick is accepted only in IDLE with enable=1.
  - On acceptance, latch sample_in, all tap_delay values and wr_ptr as base_ptr.
- WRITE: mem_addr=base_ptr, mem_we=1, mem_wdata=latched sample. wr_ptr increments modulo 2^ADDR_W at the end of this cycle.
- READ k: mem_addr = (base_ptr - D_k) mod 2^ADDR_W, mem_we=0.
  - D_k is the integer part of tap k's delay, clamped to the range 1..2^ADDR_W-1.
  - D=0 becomes 1, so a tap never reads the slot being written.
- Data capture: mem_rdata for tap k is captured one cycle after READ k. The last capture happens in DRAIN.
- DONE: tap_data is updated with all taps at once and tap_valid=1 for exactly this cycle. tap_data holds until the next DONE.
- Latency: tick in cycle 0 -> tap_valid in cycle NUM_TAPS+3 (cycle 6 for the defaults).
- Inter-tick spacing: ticks must be at least NUM_TAPS+4 cycles apart. At 48 kHz there are about 1041 cycles per sample, so this holds with a large margin.
- Tick while busy: the tick is dropped, overrun is set, and the current sequence is unaffected.
- clear_overrun and a new overrun in the same cycle: set wins.
- enable falling mid-sequence: the sequence completes normally. Further ticks are ignored with no overrun.
- Address arithmetic is unsigned modulo 2^ADDR_W, so wrap-around needs no special case.

Optional Feature:
- Macro: DELAY_LINE_INTERP_EN.
- Defined:
  - Each tap reads two addresses: A=(base_ptr-D_k) and A-1, in consecutive READ cycles (2*NUM_TAPS READ cycles total).
  - Output = s0 + (((s1-s0) * frac) >>> FRAC_W), where s0 and s1 are the samples read from A and A-1.
  - The difference is computed at DATA_W+1 bits signed, the product at DATA_W+FRAC_W+1 bits, and the result is truncated to DATA_W.
  - One extra register stage is added. Latency = 2*NUM_TAPS+4 cycles; minimum tick spacing = 2*NUM_TAPS+5 cycles.
  - D_k is clamped to 1..2^ADDR_W-2.
- Undefined: fractional bits are ignored (truncated), with timing as described in Behaviour.

Test Plan:
- After reset, write 0x100+n on ticks n=0..9 spaced 20 cycles apart; tap_delay = {3,2,1}<<FRAC_W -> on tick 9, tap_valid at cycle +6 with tap0=0x108, tap1=0x107, tap2=0x106.
- Wrap-around: run 2050 ticks with sample_in = tick index; on tick 2049 with delay 480 (all taps) -> mem_addr for the reads = 1569 and every tap = 1569.
- Clamping: delay 0 -> read address = base_ptr-1, and the WRITE-cycle address is never re-read.
- Overrun: a second tick 2 cycles after the first -> overrun=1, exactly one tap_valid, wr_ptr advanced by 1. clear_overrun -> overrun=0.
- Reset asserted in cycle 3 of a sequence -> all outputs 0 immediately, no tap_valid, and the next tick writes address 0.
- With DELAY_LINE_INTERP_EN: delay = 2.5 (frac 8/16), stored samples 100 (delay 2) and 200 (delay 3) -> tap = 150, tap_valid at cycle 2*NUM_TAPS+4.
